// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write, issue-mark and status bundle of the multi-port register file
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NR   = 6,
  parameter int NW   = 2
);
  logic [NR*AW-1:0]   raddr;
  logic [NR*XLEN-1:0] rdata;
  logic [NR-1:0]      rbusy;
  logic [NW-1:0]      we;
  logic [NW*AW-1:0]   waddr;
  logic [NW*XLEN-1:0] wdata;
  logic [NW-1:0]      wsb;
  logic [NW-1:0]      iss_en;
  logic [NW*AW-1:0]   iss_addr;
  logic               flush;
  logic               err_ovf;
  logic               err_udf;

  modport master (
    output raddr, we, waddr, wdata, wsb, iss_en, iss_addr, flush,
    input  rdata, rbusy, err_ovf, err_udf
  );

  modport slave (
    input  raddr, we, waddr, wdata, wsb, iss_en, iss_addr, flush,
    output rdata, rbusy, err_ovf, err_udf
  );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with pending-write scoreboard; RF_BYPASS_EN adds write-to-read bypass
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NR   = 6,
  parameter int NW   = 2,
  parameter int PW   = 2
) (
  input logic         clk,
  input logic         resetn,
  regfile_mp_if.slave rf
);
  localparam int NREG = 2**AW;
  localparam int CMAX = 2**PW - 1;

  logic [XLEN-1:0] regs    [NREG];
  logic [PW-1:0]   cnt     [NREG];
  logic [PW-1:0]   cnt_nxt [NREG];
  logic            ovf_set;
  logic            udf_set;
  logic            err_ovf_q;
  logic            err_udf_q;
`ifdef RF_BYPASS_EN
  int              dec_n   [NREG];
`endif

  // Net pending count per register; register 0 never tracks anything.
  always_comb begin
    int inc;
    int dec;
    int nxt;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    inc = 0;
    dec = 0;
    nxt = 0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt[r] = '0;
`ifdef RF_BYPASS_EN
      dec_n[r] = 0;
`endif
    end
    for (int r = 1; r < NREG; r++) begin
      inc = 0;
      dec = 0;
      for (int j = 0; j < NW; j++) begin
        if (rf.iss_en[j] && rf.iss_addr[j*AW +: AW] == AW'(r))
          inc = inc + 1;
        if (rf.we[j] && rf.wsb[j] && rf.waddr[j*AW +: AW] == AW'(r))
          dec = dec + 1;
      end
`ifdef RF_BYPASS_EN
      dec_n[r] = dec;
`endif
      nxt = (rf.flush ? 0 : int'(cnt[r])) + inc - dec;
      if (nxt > CMAX) begin
        cnt_nxt[r] = PW'(CMAX);
        ovf_set    = 1'b1;
      end else if (nxt < 0) begin
        cnt_nxt[r] = '0;
        udf_set    = 1'b1;
      end else begin
        cnt_nxt[r] = PW'(nxt);
      end
    end
  end

  // Ascending port order: the last non-blocking write (youngest port) wins a collision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (rf.we[j] && rf.waddr[j*AW +: AW] != '0)
          regs[rf.waddr[j*AW +: AW]] <= rf.wdata[j*XLEN +: XLEN];
      end
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
      if (ovf_set) err_ovf_q <= 1'b1;
      if (udf_set) err_udf_q <= 1'b1;
    end
  end

  assign rf.err_ovf = err_ovf_q;
  assign rf.err_udf = err_udf_q;

  always_comb begin
    logic [AW-1:0] ra;
    ra       = '0;
    rf.rdata = '0;
    rf.rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      ra = rf.raddr[i*AW +: AW];
      rf.rdata[i*XLEN +: XLEN] = regs[ra];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NW; j++) begin
        if (rf.we[j] && ra != '0 && rf.waddr[j*AW +: AW] == ra)
          rf.rdata[i*XLEN +: XLEN] = rf.wdata[j*XLEN +: XLEN];
      end
      rf.rbusy[i] = (int'(cnt[ra]) - dec_n[ra]) > 0;
`else
      rf.rbusy[i] = cnt[ra] != '0;
`endif
    end
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file for the dual/multi-issue MIPS core.
- Replaces the fixed 6-read / 2-write file. Adds:
  - an asynchronous clear of all registers;
  - parametrised width, depth and port counts;
  - priority resolution when write ports collide;
  - a per-register pending-write scoreboard (saturating counters) that issue logic reads to detect RAW hazards.
- Sits between decode/issue (reads, issue marks) and writeback (writes, scoreboard release).

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; NREG = 2**AW registers (localparam).
- NR, 6, number of read ports.
- NW, 2, number of write ports; also the number of issue-mark ports.
- PW, 2, width of each pending-write counter; maximum count is 2**PW-1.

Ports:
- clk  in  1  core clock; everything changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- raddr  in  NR*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NR*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rbusy  out  NR  port i's register has outstanding scoreboarded writes.
- we  in  NW  write enables.
- waddr  in  NW*AW  write addresses.
- wdata  in  NW*XLEN  write data.
- wsb  in  NW  the write on this port releases one scoreboard entry (qualified by we).
- iss_en  in  NW  issue mark: one future write to iss_addr is now pending.
- iss_addr  in  NW*AW  issue-mark destination addresses.
- flush  in  1  synchronous clear of all pending counters.
- err_ovf  out  1  sticky flag: a pending counter saturated.
- err_udf  out  1  sticky flag: a scoreboard release hit a zero counter.

Behaviour:
- Reset (resetn low, asynchronous):
  - all registers, all counters, err_ovf and err_udf go to 0;
  - rdata therefore reads 0 and rbusy reads 0.
  - Writes, issue marks and flush are ignored while resetn is low.
- Register 0:
  - hardwired to zero; reads always return 0 and rbusy is 0;
  - writes, issue marks and releases addressed to register 0 are dropped;
  - none of these sets err_ovf or err_udf.
- Reads: combinational from the current register state, on every port independently. Same-cycle writes are invisible unless RF_BYPASS_EN is defined.
- Writes:
  - take effect at the rising edge when we[j] is 1;
  - if several enabled ports target the same address, the highest port index wins (port NW-1 is the youngest instruction);
  - non-colliding ports all write in the same cycle.
- Scoreboard, per register r (r != 0):
  - inc = number of ports j with iss_en[j] and iss_addr_j == r.
  - dec = number of ports j with we[j], wsb[j] and waddr_j == r.
  - base = 0 if flush is 1, otherwise cnt[r].
  - next = base + inc - dec, computed one bit wider than PW plus enough to hold NW.
  - If next > 2**PW-1: cnt[r] saturates at 2**PW-1 and err_ovf is set.
  - If next < 0: cnt[r] is clamped to 0 and err_udf is set.
  - Simultaneous issue and release on the same register net out: cnt=1, inc=1, dec=1 leaves cnt at 1 with no error.
  - When flush is 1, releases in that cycle count against 0 (so they underflow); issues in that cycle survive the flush.
- rbusy[i] is 1 exactly when cnt[raddr_i] != 0, using the registered counter value.
- err_ovf and err_udf stay set until reset.
- Latency: data and counter updates are visible on the cycle after the edge; reads add 0 cycles.

Optional Feature:
- RF_BYPASS_EN defined:
  - rdata[i] returns the same-cycle winning wdata when some we[j] targets raddr_i (≠ 0), using the same highest-index priority as writes;
  - rbusy[i] is computed as (cnt[raddr_i] - dec[raddr_i]) != 0, clamped at 0;
  - adds a combinational path from the write ports to the read ports.
- Not defined: reads and rbusy come only from registered state; there is no path from wdata to rdata.

Test Plan:
- Reset: assert resetn=0 mid-run after writing reg 5 = 0x1234 -> rdata for raddr=5 reads 0 immediately and rbusy=0. Release resetn; all counters and err flags stay 0.
- Write collision: we=2'b11, both waddr=7, wdata0=0xAAAA0000, wdata1=0x5555FFFF -> next cycle reg 7 = 0x5555FFFF. Separately, a write of 0xDEAD to reg 0 reads back 0.
- Six-port read: load regs 1..6 with 0x11..0x66, set raddr = {6,5,4,3,2,1} -> rdata ports 0..5 = 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 in the same cycle.
- Scoreboard:
  1. Issue to reg 9 on both ports in one cycle -> cnt=2, rbusy=1.
  2. One wsb write to reg 9 -> cnt=1, rbusy=1.
  3. Same cycle: issue to reg 9 plus one wsb write to reg 9 -> cnt stays 1.
  4. Final wsb write -> cnt=0, rbusy=0.
- Errors: issue to reg 3 four times with PW=2 -> cnt=3 and err_ovf=1. A wsb write to reg 4 while its cnt=0 -> err_udf=1 and cnt stays 0. Both flags remain set until reset.
- Flush and bypass:
  - flush together with an issue to reg 8 while cnt[8]=2 -> cnt[8]=1.
  - With RF_BYPASS_EN: write 0xCAFE to reg 10 while raddr=10 -> rdata=0xCAFE in the same cycle.
  - Without RF_BYPASS_EN: the same stimulus reads the old value that cycle and 0xCAFE the next cycle.
